// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
// Registered N-way ALU operand selector with EX/MEM and MEM/WB forwarding.
// The selected operand sits in a single valid/ready output register with flush.
// Optional feature macro: OPMUX_FWD_STATS_EN adds saturating forwarding counters
// (fwd_exmem_cnt, fwd_memwb_cnt); without it those ports do not exist.
module operand_fwd_mux #(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 4,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic                     use_rs,
    input  logic [REG_ADDR_W-1:0]    rs_addr,
    input  logic                     exmem_wr_en,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [WIDTH-1:0]         exmem_data,
    input  logic                     memwb_wr_en,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic [WIDTH-1:0]         memwb_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_fwd
`ifdef OPMUX_FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]         fwd_exmem_cnt,
    output logic [CNT_W-1:0]         fwd_memwb_cnt
`endif
);

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [1:0]       sel_fwd_s;
    logic             fwd_ok_s;
    logic             exmem_hit_s;
    logic             memwb_hit_s;
    logic             accept_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [1:0]       out_fwd_r;

    // A new operand may enter whenever the output register is empty or draining.
    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready && !flush;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_fwd   = out_fwd_r;

    // Base channel select; an index with no matching channel leaves the value at zero.
    always_comb begin
        base_s = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            base_s = base_s | ({WIDTH{src_sel == SEL_W'(k)}} & src_data[k*WIDTH +: WIDTH]);
        end
    end

    // Register x0 is hard-wired zero, so it is never a forwarding target.
    assign fwd_ok_s    = use_rs && (rs_addr != {REG_ADDR_W{1'b0}});
    assign exmem_hit_s = fwd_ok_s && exmem_wr_en && (exmem_rd == rs_addr);
    assign memwb_hit_s = fwd_ok_s && memwb_wr_en && (memwb_rd == rs_addr);

    // Forwarding override: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        sel_data_s = base_s;
        sel_fwd_s  = FWD_NONE;
        if (exmem_hit_s) begin
            sel_data_s = exmem_data;
            sel_fwd_s  = FWD_EXMEM;
        end else if (memwb_hit_s) begin
            sel_data_s = memwb_data;
            sel_fwd_s  = FWD_MEMWB;
        end else begin
            sel_data_s = base_s;
            sel_fwd_s  = FWD_NONE;
        end
    end

    // Output pipeline register: load on accept, drain on consume or flush, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_fwd_r   <= FWD_NONE;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_fwd_r   <= sel_fwd_s;
        end else if (flush || out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef OPMUX_FWD_STATS_EN
    logic [CNT_W-1:0] exmem_cnt_r;
    logic [CNT_W-1:0] memwb_cnt_r;

    assign fwd_exmem_cnt = exmem_cnt_r;
    assign fwd_memwb_cnt = memwb_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Forwarding statistics, counted per accepted operand and saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_cnt_r <= {CNT_W{1'b0}};
            memwb_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && (sel_fwd_s == FWD_EXMEM)) begin
            exmem_cnt_r <= sat_inc(exmem_cnt_r);
        end else if (accept_s && (sel_fwd_s == FWD_MEMWB)) begin
            memwb_cnt_r <= sat_inc(memwb_cnt_r);
        end else begin
            exmem_cnt_r <= exmem_cnt_r;
            memwb_cnt_r <= memwb_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_operand_fwd_mux.sv
// Self-checking bench for operand_fwd_mux: directed cases plus a random phase,
// with a queue-based scoreboard checked whenever the ALU side consumes an operand.
module tb_operand_fwd_mux;

    localparam int W  = 32;
    localparam int NS = 4;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        src_sel;
    logic [NS*W-1:0]   src_data;
    logic              use_rs;
    logic [AW-1:0]     rs_addr;
    logic              exmem_wr_en;
    logic [AW-1:0]     exmem_rd;
    logic [W-1:0]      exmem_data;
    logic              memwb_wr_en;
    logic [AW-1:0]     memwb_rd;
    logic [W-1:0]      memwb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [1:0]        out_fwd;
`ifdef OPMUX_FWD_STATS_EN
    logic [1:0]        fwd_exmem_cnt;
    logic [1:0]        fwd_memwb_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [W+1:0] sb_q[$];
    logic         model_valid = 1'b0;

    operand_fwd_mux #(.WIDTH(W), .NUM_SRC(NS), .REG_ADDR_W(AW), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src_sel(src_sel), .src_data(src_data), .use_rs(use_rs), .rs_addr(rs_addr),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_fwd(out_fwd)
`ifdef OPMUX_FWD_STATS_EN
        , .fwd_exmem_cnt(fwd_exmem_cnt), .fwd_memwb_cnt(fwd_memwb_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference operand for the current inputs, packed as {fwd, data}.
    function automatic logic [W+1:0] model_op();
        logic [W-1:0] base;
        base = '0;
        if (int'(src_sel) < NS) base = src_data[int'(src_sel)*W +: W];
        if (use_rs && rs_addr != 5'd0 && exmem_wr_en && exmem_rd == rs_addr)
            return {2'b10, exmem_data};
        else if (use_rs && rs_addr != 5'd0 && memwb_wr_en && memwb_rd == rs_addr)
            return {2'b01, memwb_data};
        else
            return {2'b00, base};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, evaluated mid-cycle while inputs and outputs are stable.
    always @(negedge clk) begin
        logic [W+1:0] e;
        logic         acc;
        if (rst) begin
            sb_q.delete();
            model_valid = 1'b0;
        end else begin
            check_eq("out_valid", {63'd0, out_valid}, {63'd0, model_valid});
            check_eq("in_ready", {63'd0, in_ready}, {63'd0, (!model_valid || out_ready)});
            acc = in_valid && (!model_valid || out_ready) && !flush;
            if (model_valid && (out_ready || flush)) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_empty", 64'd0, 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    if (out_ready) begin
                        check_eq("sb_data", {32'd0, out_data}, {32'd0, e[W-1:0]});
                        check_eq("sb_fwd", {62'd0, out_fwd}, {62'd0, e[W+1:W]});
                    end
                end
            end
            if (acc) sb_q.push_back(model_op());
            model_valid = acc ? 1'b1 : ((flush || out_ready) ? 1'b0 : model_valid);
        end
    end

    task automatic idle_inputs();
        in_valid = 1'b0; src_sel = 2'd0; src_data = '0; use_rs = 1'b0; rs_addr = 5'd0;
        exmem_wr_en = 1'b0; exmem_rd = 5'd0; exmem_data = 32'd0;
        memwb_wr_en = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_data", {32'd0, out_data}, 64'd0);
        check_eq("rst_fwd", {62'd0, out_fwd}, 64'd0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Mid-transfer reset: hold an operand, then reset between edges.
        in_valid = 1'b1; src_sel = 2'd2; src_data[2*W +: W] = 32'hDEAD_BEEF; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        check_eq("pre_rst_data", {32'd0, out_data}, 64'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("mid_rst_data", {32'd0, out_data}, 64'd0);
        check_eq("mid_rst_fwd", {62'd0, out_fwd}, 64'd0);
        cycle();
        rst = 1'b0;
        idle_inputs();
        cycle();

        // Plain select of channel 1, no forwarding.
        in_valid = 1'b1; src_sel = 2'd1; src_data[W +: W] = 32'h0000_00FF; use_rs = 1'b0;
        cycle();
        in_valid = 1'b0;
        check_eq("sel_data", {32'd0, out_data}, 64'hFF);
        check_eq("sel_fwd", {62'd0, out_fwd}, 64'd0);
        cycle();

        // Both stages hit: EX/MEM wins.
        in_valid = 1'b1; src_sel = 2'd0; src_data[0 +: W] = 32'h1234; use_rs = 1'b1; rs_addr = 5'd5;
        exmem_wr_en = 1'b1; exmem_rd = 5'd5; exmem_data = 32'hAAAA;
        memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBBBB;
        cycle();
        check_eq("prio_data", {32'd0, out_data}, 64'hAAAA);
        check_eq("prio_fwd", {62'd0, out_fwd}, 64'h2);
        // Only MEM/WB hits.
        exmem_rd = 5'd6;
        cycle();
        check_eq("memwb_data", {32'd0, out_data}, 64'hBBBB);
        check_eq("memwb_fwd", {62'd0, out_fwd}, 64'h1);
        // rs = x0 never forwards.
        rs_addr = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0;
        cycle();
        check_eq("x0_data", {32'd0, out_data}, 64'h1234);
        check_eq("x0_fwd", {62'd0, out_fwd}, 64'd0);
        idle_inputs();
        cycle();

        // Stall for three cycles, then release.
        in_valid = 1'b1; src_sel = 2'd1; src_data[W +: W] = 32'h11; out_ready = 1'b0;
        cycle();
        src_data[W +: W] = 32'h22;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_ready", {63'd0, in_ready}, 64'd0);
            check_eq("stall_data", {32'd0, out_data}, 64'h11);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        check_eq("release_data", {32'd0, out_data}, 64'h22);
        check_eq("release_valid", {63'd0, out_valid}, 64'd1);

        // Flush drops the incoming request and holds the old data.
        src_data[W +: W] = 32'h33; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
        check_eq("flush_data", {32'd0, out_data}, 64'h22);
        cycle();

        // Random traffic; the scoreboard monitor does the checking.
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom % 4) != 0;
            out_ready   = ($urandom % 4) != 0;
            flush       = ($urandom % 16) == 0;
            src_sel     = 2'($urandom);
            src_data    = {$urandom, $urandom, $urandom, $urandom};
            use_rs      = 1'($urandom);
            rs_addr     = 5'($urandom_range(0, 3));
            exmem_wr_en = 1'($urandom);
            exmem_rd    = 5'($urandom_range(0, 3));
            exmem_data  = $urandom;
            memwb_wr_en = 1'($urandom);
            memwb_rd    = 5'($urandom_range(0, 3));
            memwb_data  = $urandom;
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);

`ifdef OPMUX_FWD_STATS_EN
        // Saturating counters with a 2-bit width.
        #2 rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        in_valid = 1'b1; use_rs = 1'b1; rs_addr = 5'd3;
        exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_data = 32'h77;
        repeat (5) cycle();
        idle_inputs();
        cycle();
        check_eq("cnt_exmem", {62'd0, fwd_exmem_cnt}, 64'd3);
        check_eq("cnt_memwb", {62'd0, fwd_memwb_cnt}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
